// File: rtl/perceptron_pkg.sv
// Shared sizing, weight/row types and trainer states for the perceptron predictor.
package perceptron_pkg;
  localparam int unsigned PERCEPTRON_NUMBER = 62;
  localparam int unsigned WIDTH             = 8;
  localparam int unsigned ROW_BITS          = 6;
  localparam int unsigned ROWS              = 1 << ROW_BITS;
  localparam int unsigned THETA             = 133;

  typedef logic signed [WIDTH-1:0] weight_t;
  typedef weight_t [PERCEPTRON_NUMBER-1:0] row_t;

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} trainer_state_e;
endpackage

// File: rtl/perceptron_row_update.sv
// Applies one training step to a weight row: w[i] += t*x[i], clamped to +/-(2**(WIDTH-1)-1).
module perceptron_row_update
  import perceptron_pkg::*;
(
  input  row_t                         row_i,
  input  logic [PERCEPTRON_NUMBER-1:0] history_i,
  input  logic                         taken_i,
  output row_t                         row_o
);
  localparam logic signed [WIDTH:0] ONE  = (WIDTH+1)'(1);
  localparam logic signed [WIDTH:0] MAXV = (WIDTH+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [WIDTH:0] MINV = -MAXV;

  for (genvar gi = 0; gi < PERCEPTRON_NUMBER; gi++) begin : g_w
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] s;
    assign ext = {row_i[gi][WIDTH-1], row_i[gi]};
    // t*x is +1 exactly when outcome and history bit agree
    assign s   = (taken_i == history_i[gi]) ? ext + ONE : ext - ONE;
    assign row_o[gi] = (s > MAXV) ? MAXV[WIDTH-1:0] :
                       (s < MINV) ? MINV[WIDTH-1:0] : s[WIDTH-1:0];
  end
endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron weight table + speculative GHR: combinational fetch lookup, 2-cycle
// read-modify-write retraining on resolve, and GHR repair on mispredict.
module perceptron_trainer
  import perceptron_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  pred_pc,
  input  logic                         pred_fire,
  input  logic                         pred_taken,
  output row_t                         weights,
  output logic [PERCEPTRON_NUMBER-1:0] history,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [31:0]                  upd_pc,
  input  logic [PERCEPTRON_NUMBER-1:0] upd_history,
  input  logic signed [31:0]           upd_sum,
  input  logic                         upd_taken,
  input  logic                         upd_mispred,
  output logic                         init_done
);
  localparam int unsigned N = PERCEPTRON_NUMBER;

  trainer_state_e      state_q, state_d;
  logic [ROW_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic                init_done_q, init_done_d;
  logic [N-1:0]        ghr_q, ghr_d;
  logic [ROW_BITS-1:0] row_idx_q, row_idx_d;
  logic [N-1:0]        hist_q, hist_d;
  logic                taken_q, taken_d;
  row_t                row_q, row_d;
  row_t                new_row;
  row_t                table_q [ROWS];

  logic                tbl_we;
  logic [ROW_BITS-1:0] tbl_waddr;
  row_t                tbl_wdata;
  logic                upd_fire;
  logic                train;
  logic signed [32:0]  sum_ext;
  logic [32:0]         abs_sum;
  logic                unused_bits;

  assign sum_ext  = {upd_sum[31], upd_sum};
  assign abs_sum  = sum_ext[32] ? 33'(-sum_ext) : 33'(sum_ext);
  assign train    = upd_mispred | (abs_sum <= 33'(THETA));
  assign upd_fire = upd_valid & (state_q == IDLE);

  assign weights   = table_q[pred_pc[ROW_BITS+1:2]];
  assign history   = ghr_q;
  assign init_done = init_done_q;

  assign unused_bits = ^{pred_pc[31:ROW_BITS+2], pred_pc[1:0],
                         upd_pc[31:ROW_BITS+2], upd_pc[1:0], upd_history[N-1]};

  perceptron_row_update u_row_update (
    .row_i     (row_q),
    .history_i (hist_q),
    .taken_i   (taken_q),
    .row_o     (new_row)
  );

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    row_idx_d   = row_idx_q;
    hist_d      = hist_q;
    taken_d     = taken_q;
    row_d       = row_q;
    tbl_we      = 1'b0;
    tbl_waddr   = row_idx_q;
    tbl_wdata   = new_row;
    upd_ready   = 1'b0;
    case (state_q)
      INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = clr_ptr_q;
        tbl_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ROW_BITS'(ROWS - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_fire) begin
          row_idx_d = upd_pc[ROW_BITS+1:2];
          hist_d    = upd_history;
          taken_d   = upd_taken;
          if (train) state_d = READ;
        end
      end
      READ: begin
        row_d   = table_q[row_idx_q];
        state_d = WRITE;
      end
      WRITE: begin
        tbl_we  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ghr_d = ghr_q;
    if (state_q != INIT) begin
      if (upd_fire && upd_mispred) ghr_d = {upd_history[N-2:0], upd_taken};
      else if (pred_fire)          ghr_d = {ghr_q[N-2:0], pred_taken};
    end
  end

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= INIT;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
      ghr_q       <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    row_idx_q <= row_idx_d;
    hist_q    <= hist_d;
    taken_q   <= taken_d;
    row_q     <= row_d;
  end

  // Reset suppresses an in-flight WRITE so no partial row lands in the table
  always_ff @(posedge clk) begin
    if (tbl_we && !rst_n) table_q[tbl_waddr] <= tbl_wdata;
  end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: table-driven training decisions,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_perceptron_trainer;
  import perceptron_pkg::*;
  localparam int N  = PERCEPTRON_NUMBER;
  localparam int RW = PERCEPTRON_NUMBER * WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [31:0]        pred_pc = '0;
  logic               pred_fire = 1'b0, pred_taken = 1'b0;
  row_t               weights;
  logic [N-1:0]       history;
  logic               upd_valid = 1'b0, upd_ready;
  logic [31:0]        upd_pc = '0;
  logic [N-1:0]       upd_history = '0;
  logic signed [31:0] upd_sum = '0;
  logic               upd_taken = 1'b0, upd_mispred = 1'b0;
  logic               init_done;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_fire(pred_fire),
    .pred_taken(pred_taken), .weights(weights), .history(history),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_history(upd_history), .upd_sum(upd_sum), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed weights, GHR, and a pending write that lands
  // two cycles after a training update is accepted.
  int           mw [ROWS][N];
  int           pend [N];
  int           pend_row;
  int           busy;
  bit           minit;
  logic [N-1:0] mghr;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int row_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic [RW-1:0] mrow(input int r);
    logic [RW-1:0] v;
    int x;
    for (int i = 0; i < N; i++) begin
      x = mw[r][i];
      v[i*WIDTH +: WIDTH] = x[WIDTH-1:0];
    end
    return v;
  endfunction

  function automatic logic [RW-1:0] const_row(input int val);
    logic [RW-1:0] v;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = val[WIDTH-1:0];
    return v;
  endfunction

  function automatic bit m_train(input int s, input bit mis);
    longint a;
    a = (s < 0) ? -longint'(s) : longint'(s);
    return mis || (a <= longint'(THETA));
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < N; i++) mw[r][i] = 0;
    mghr  = '0;
    busy  = 0;
    minit = 0;
  endtask

  // One clock: advance the model across the edge, then compare DUT outputs.
  task automatic tick();
    bit fire;
    int r, x;
    fire = upd_valid && minit && (busy == 0);
    @(posedge clk);
    if (busy > 0) begin
      busy--;
      if (busy == 0) mw[pend_row] = pend;
    end
    if (fire && m_train(upd_sum, upd_mispred)) begin
      r = row_of(upd_pc);
      for (int i = 0; i < N; i++) begin
        x = mw[r][i] + ((upd_taken == upd_history[i]) ? 1 : -1);
        if (x > 127)  x = 127;
        if (x < -127) x = -127;
        pend[i] = x;
      end
      pend_row = r;
      busy     = 2;
    end
    if (fire && upd_mispred)     mghr = {upd_history[N-2:0], upd_taken};
    else if (pred_fire && minit) mghr = {mghr[N-2:0], pred_taken};
    #1;
    chk("ready", RW'(upd_ready), RW'(minit && busy == 0));
    chk("history", RW'(history), RW'(mghr));
    chk("lookup", weights, mrow(row_of(pred_pc)));
  endtask

  task automatic do_reset();
    int n;
    upd_valid = 1'b0;
    pred_fire = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    n = 0;
    while (!upd_ready && n < 200) begin
      chk("init_done_low", RW'(init_done), RW'(0));
      n++;
      @(posedge clk);
      #1;
    end
    chk("init_cycles", RW'(n), RW'(64));
    chk("init_done", RW'(init_done), RW'(1));
    chk("history_reset", RW'(history), RW'(0));
    minit = 1;
    for (int r = 0; r < ROWS; r++) begin
      pred_pc = 32'(r) << 2;
      #1;
      chk("row_zero", weights, const_row(0));
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [N-1:0] h,
                      input int s, input bit t, input bit m);
    int k;
    k = 0;
    while (!upd_ready && k < 10) begin
      tick();
      k++;
    end
    chk("ready_wait", RW'(upd_ready), RW'(1));
    upd_pc      = pc;
    upd_history = h;
    upd_sum     = s;
    upd_taken   = t;
    upd_mispred = m;
    upd_valid   = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_hist();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[N-1:0];
  endfunction

  typedef struct {
    int sum;
    bit mispred;
    bit exp_train;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{200, 1'b0, 1'b0};
    vecs[1] = '{-133, 1'b0, 1'b1};
    vecs[2] = '{133, 1'b0, 1'b1};
    vecs[3] = '{134, 1'b0, 1'b0};
    vecs[4] = '{-134, 1'b0, 1'b0};
    vecs[5] = '{32'sh8000_0000, 1'b0, 1'b0};
    vecs[6] = '{200, 1'b1, 1'b1};
    vecs[7] = '{0, 1'b0, 1'b1};

    do_reset();

    // First training update on row 16: visible only after the WRITE edge.
    pred_pc = 32'h40;
    send(32'h40, '1, 0, 1'b1, 1'b1);
    chk("rmw_busy", RW'(upd_ready), RW'(0));
    chk("rmw_pre", weights, const_row(0));
    tick();
    chk("rmw_prewrite", weights, const_row(0));
    tick();
    chk("rmw_done", weights, const_row(1));
    pred_pc = 32'h44;
    #1;
    chk("other_row", weights, const_row(0));
    pred_pc = 32'h40;

    // Saturation at +127 and at -127.
    for (int i = 0; i < 130; i++) send(32'h40, '1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("sat_pos", weights, const_row(127));
    for (int i = 0; i < 260; i++) send(32'h40, '1, 0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("sat_neg", weights, const_row(-127));

    // Training decision across the threshold boundaries.
    pred_pc = 32'h80;
    foreach (vecs[v]) begin
      send(32'h80, rand_hist(), vecs[v].sum, 1'($urandom_range(0, 1)), vecs[v].mispred);
      chk("vec_ready", RW'(upd_ready), RW'(!vecs[v].exp_train));
      repeat (3) tick();
    end

    // Repair beats a simultaneous speculative shift.
    pred_taken = 1'b1;
    pred_fire  = 1'b1;
    repeat (3) tick();
    send(32'h0, '0, 0, 1'b0, 1'b1);
    pred_fire = 1'b0;
    chk("repair_wins", RW'(history), RW'(0));
    repeat (3) tick();

    // Randomized traffic, valid held across busy cycles.
    for (int c = 0; c < 600; c++) begin
      pred_pc    = {24'($urandom()), 2'($urandom_range(0, 3)), 6'($urandom())} & 32'hFFFF_FF0C;
      pred_fire  = 1'($urandom_range(0, 1));
      pred_taken = 1'($urandom_range(0, 1));
      if (!upd_valid || upd_ready) begin
        upd_valid   = ($urandom_range(0, 1) == 1);
        upd_pc      = {$urandom()} & 32'hFFFF_FF0F;
        upd_history = rand_hist();
        upd_sum     = ($urandom_range(0, 2) == 0) ? int'($urandom()) : ($urandom_range(0, 280) - 140);
        upd_taken   = 1'($urandom_range(0, 1));
        upd_mispred = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    upd_valid = 1'b0;
    pred_fire = 1'b0;
    repeat (3) tick();

    // Reset landing on a WRITE cycle leaves a clean, all-zero table.
    send(32'h14, '1, 0, 1'b1, 1'b1);
    tick();
    do_reset();

    // Back-to-back non-training updates are accepted every cycle.
    upd_pc      = 32'h20;
    upd_sum     = 1000;
    upd_mispred = 1'b0;
    upd_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      upd_history = rand_hist();
      upd_taken   = 1'($urandom_range(0, 1));
      tick();
      chk("b2b_ready", RW'(upd_ready), RW'(1));
    end
    upd_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
